fifo_sync_ctrl: RTL and testbench
=================================

# fifo_sync_ctrl

Single-clock, parametrised synchronous FIFO, the successor to the team's dual-clock FIFO for paths where producer and consumer share one clock. Adds these features:
- asynchronous active-low reset
- occupancy count
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow error flags
- registered, valid-qualified read data

Sits between single-domain stream producers and consumers, e.g. buffering ahead of packet formatters.

## Interface
- WIDTH, 64, data word width in bits.
- DEPTH, 256, number of entries; must equal 2**ALENGTH.
- ALENGTH, 8, address width; pointers are ALENGTH+1 bits (extra wrap bit).
- AF_LEVEL, 224, almost_full asserts when count >= AF_LEVEL (range 1..DEPTH).
- AE_LEVEL, 32, almost_empty asserts when count <= AE_LEVEL (range 0..DEPTH-1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- rd_en  in  1  read request (standard mode) / head acknowledge (FWFT mode).
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data qualifier.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ALENGTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

## Operation
- Storage: DEPTH x WIDTH array, indexed by wr_ptr[ALENGTH-1:0] and rd_ptr[ALENGTH-1:0].
- Pointers increment modulo 2**(ALENGTH+1).
- count = wr_ptr - rd_ptr, truncated to ALENGTH+1 bits.
- Write accept: wr_en && !full. The word is stored at wr_ptr and wr_ptr increments.
- Read accept: rd_en && !empty. rd_ptr increments.
- Write while full: rejected, no state change except overflow <= 1.
- Read while empty: rejected, no state change except underflow <= 1.
- Simultaneous accepted write and read: both pointers advance and count is unchanged.
- full and empty are evaluated on the pre-edge count, so a write is rejected when full even if a read is accepted in the same cycle.
- Flags are combinational decodes of count.
  - DEPTH reachable: full=1, count=DEPTH (e.g. 9'd256).
  - empty=1 at count 0.
- clr_err: overflow and underflow cleared at the next edge. If a new error occurs in the same cycle as clr_err, the set wins.
- Reset values:
  - pointers 0, count 0
  - empty 1, almost_empty 1, full 0, almost_full 0
  - rd_valid 0, rd_data 0
  - overflow 0, underflow 0
  - Array contents are not reset.
- Reset mid-operation discards all contents immediately (asynchronous). Outputs take their reset values while rst_n is low.

## Timing
- Standard mode: an accepted read at edge N presents the head word on rd_data with rd_valid=1 after edge N.
  - rd_valid is a one-cycle pulse per accepted read.
  - Back-to-back reads give one word per cycle.
- Write-to-flag latency: a write accepted at edge N updates count, empty, almost_* and full after edge N.
  - A read may be accepted at edge N+1 (write-to-read latency 1 cycle).
- count, flags and errors are all valid the cycle after the causing edge.
- Wrap-around: pointer bit ALENGTH toggles on every DEPTH increments. full and empty must stay correct across repeated wraps.

## Configuration
- FIFO_SYNC_FWFT_EN defined (first-word-fall-through):
  - rd_data always shows the head entry, registered.
  - rd_valid = !empty, delayed to align with the registered rd_data.
  - rd_en pops the current head; the next word appears after the same edge.
  - Write-to-rd_valid latency on an empty FIFO is 1 cycle.
  - Underflow is flagged on rd_en while rd_valid=0.
- FIFO_SYNC_FWFT_EN undefined: standard mode as described under Timing; rd_data holds its last value between reads.

## Test plan
- Reset, then write 0x11,0x22,0x33, read 3 times -> rd_data 0x11,0x22,0x33 with rd_valid pulses one cycle after each accepted rd_en; count 3->0; empty=1 at end.
- Fill 256 words with no reads -> almost_full rises when count reaches 224, full=1 at count 256. A 257th write leaves count=256 and sets overflow=1. clr_err clears overflow.
- Read on empty after reset -> rd_valid stays 0, underflow=1, pointers unchanged.
- With count=100, assert wr_en and rd_en together for 50 cycles -> count stays 100, data order preserved. Repeat for 3xDEPTH words to cross the pointer wrap several times.
- With count=5, drop rst_n mid-burst asynchronously -> count=0, empty=1, full=0, rd_valid=0 with no clock edge. After release, a new write/read returns the new data only.
- FIFO_SYNC_FWFT_EN: one write of 0xAB into the empty FIFO -> rd_valid=1 and rd_data=0xAB one cycle later without rd_en. rd_en pop -> rd_valid=0 next cycle.

Source files
------------

// File: rtl/fifo_sync_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_sync_ctrl_if                                                   |
// | Write/read handshake, status and error bundle for fifo_sync_ctrl.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fifo_sync_ctrl_if #(
  parameter int WIDTH   = 64,
  parameter int ALENGTH = 8
);
  logic               wr_en;
  logic [WIDTH-1:0]   wr_data;
  logic               rd_en;
  logic               clr_err;
  logic               full;
  logic               almost_full;
  logic               empty;
  logic               almost_empty;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_valid;
  logic [ALENGTH:0]   count;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  full, almost_full, empty, almost_empty, rd_data, rd_valid,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output full, almost_full, empty, almost_empty, rd_data, rd_valid,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_sync_ctrl                                                      |
// | Single-clock FIFO with count, almost flags and sticky error flags.  |
// | FIFO_SYNC_FWFT_EN selects first-word-fall-through read behaviour.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fifo_sync_ctrl #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 256,
  parameter int ALENGTH  = 8,
  parameter int AF_LEVEL = 224,
  parameter int AE_LEVEL = 32
) (
  input wire              clk,
  input wire              rst_n,
  fifo_sync_ctrl_if.slave bus
);

  localparam logic [ALENGTH:0] c_DEPTH    = (ALENGTH+1)'(DEPTH);
  localparam logic [ALENGTH:0] c_AF_LEVEL = (ALENGTH+1)'(AF_LEVEL);
  localparam logic [ALENGTH:0] c_AE_LEVEL = (ALENGTH+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ALENGTH:0] wr_ptr_q, wr_ptr_d;
  logic [ALENGTH:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [ALENGTH:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_acc;
  logic             w_rd_acc;

  assign w_count  = wr_ptr_q - rd_ptr_q;
  assign w_full   = (w_count == c_DEPTH);
  assign w_empty  = (w_count == '0);

`ifdef FIFO_SYNC_FWFT_EN
  // rd_valid tracks !empty exactly, so it doubles as the pop qualifier
  assign w_rd_ok  = rd_valid_q;
`else
  assign w_rd_ok  = !w_empty;
`endif

  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && w_rd_ok;
  assign wr_ptr_d = wr_ptr_q + {{ALENGTH{1'b0}}, w_wr_acc};
  assign rd_ptr_d = rd_ptr_q + {{ALENGTH{1'b0}}, w_rd_acc};

  // New errors take priority over a same-cycle clear
  assign overflow_d  = (bus.wr_en && w_full)   || (overflow_q  && !bus.clr_err);
  assign underflow_d = (bus.rd_en && !w_rd_ok) || (underflow_q && !bus.clr_err);

`ifdef FIFO_SYNC_FWFT_EN
  logic [ALENGTH:0] w_count_d;

  assign w_count_d  = wr_ptr_d - rd_ptr_d;
  assign rd_valid_d = (w_count_d != '0);

  // Head equal to the pre-edge write pointer means the word being written
  // becomes the head this edge, so it must bypass the array.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_valid_d) begin
      if (wr_ptr_q == rd_ptr_d) begin
        rd_data_d = bus.wr_data;
      end else begin
        rd_data_d = mem_q[rd_ptr_d[ALENGTH-1:0]];
      end
    end
  end
`else
  assign rd_valid_d = w_rd_acc;

  always_comb begin
    rd_data_d = rd_data_q;
    if (w_rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q[ALENGTH-1:0]];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem_q[wr_ptr_q[ALENGTH-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.count        = w_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (w_count >= c_AF_LEVEL);
  assign bus.almost_empty = (w_count <= c_AE_LEVEL);
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_sync_ctrl                                                   |
// | Vector table, corner sequences and random traffic vs a queue model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fifo_sync_ctrl;
  localparam int WIDTH    = 64;
  localparam int DEPTH    = 256;
  localparam int ALENGTH  = 8;
  localparam int AF_LEVEL = 224;
  localparam int AE_LEVEL = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_sync_ctrl_if #(.WIDTH(WIDTH), .ALENGTH(ALENGTH)) bus ();

  fifo_sync_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ALENGTH(ALENGTH),
    .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the FIFO is just a queue plus a few flags
  logic [WIDTH-1:0] m_q [$];
  logic             m_ovf, m_udf, m_rdv;
  logic [WIDTH-1:0] m_rdd;

  typedef struct {
    bit          we;
    logic [63:0] wd;
    bit          re;
    bit          ce;
    int          cnt;
    bit          emp;
    bit          rdv;
    logic [63:0] rdd;
    bit          udf;
  } vec_t;

  vec_t        tbl [12];
  logic [63:0] d;
  int          p_w;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rdv = 1'b0;
    m_rdd = '0;
  endtask

  task automatic model_step(input bit we, input logic [63:0] wd, input bit re, input bit ce);
    bit full_pre, empty_pre;
    full_pre  = (m_q.size() == DEPTH);
    empty_pre = (m_q.size() == 0);
    m_ovf = (we && full_pre) || (m_ovf && !ce);
    m_udf = (re && empty_pre) || (m_udf && !ce);
`ifndef FIFO_SYNC_FWFT_EN
    m_rdv = re && !empty_pre;
    if (m_rdv) m_rdd = m_q[0];
`endif
    if (re && !empty_pre) void'(m_q.pop_front());
    if (we && !full_pre) m_q.push_back(wd);
`ifdef FIFO_SYNC_FWFT_EN
    m_rdv = (m_q.size() != 0);
    if (m_rdv) m_rdd = m_q[0];
`endif
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".count"},        64'(bus.count),        64'(n));
    chk({tag, ".empty"},        64'(bus.empty),        64'(n == 0));
    chk({tag, ".full"},         64'(bus.full),         64'(n == DEPTH));
    chk({tag, ".almost_full"},  64'(bus.almost_full),  64'(n >= AF_LEVEL));
    chk({tag, ".almost_empty"}, 64'(bus.almost_empty), 64'(n <= AE_LEVEL));
    chk({tag, ".overflow"},     64'(bus.overflow),     64'(m_ovf));
    chk({tag, ".underflow"},    64'(bus.underflow),    64'(m_udf));
    chk({tag, ".rd_valid"},     64'(bus.rd_valid),     64'(m_rdv));
    chk({tag, ".rd_data"},      bus.rd_data,           m_rdd);
  endtask

  task automatic drive(input bit we, input logic [63:0] wd, input bit re, input bit ce);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.clr_err = ce;
  endtask

  task automatic cycle(input bit we, input logic [63:0] wd, input bit re, input bit ce,
                       input string tag);
    drive(we, wd, re, ce);
    model_step(we, wd, re, ce);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1, 64'h11, 0, 0, 1, 0, 0, 64'h0,  0};
    tbl[1]  = '{1, 64'h22, 0, 0, 2, 0, 0, 64'h0,  0};
    tbl[2]  = '{1, 64'h33, 0, 0, 3, 0, 0, 64'h0,  0};
    tbl[3]  = '{0, 64'h0,  1, 0, 2, 0, 1, 64'h11, 0};
    tbl[4]  = '{0, 64'h0,  1, 0, 1, 0, 1, 64'h22, 0};
    tbl[5]  = '{0, 64'h0,  0, 0, 1, 0, 0, 64'h22, 0};
    tbl[6]  = '{0, 64'h0,  1, 0, 0, 1, 1, 64'h33, 0};
    tbl[7]  = '{0, 64'h0,  1, 0, 0, 1, 0, 64'h33, 1};
    tbl[8]  = '{0, 64'h0,  0, 1, 0, 1, 0, 64'h33, 0};
    tbl[9]  = '{1, 64'h44, 1, 0, 1, 0, 0, 64'h33, 1};
    tbl[10] = '{1, 64'h55, 1, 1, 1, 0, 1, 64'h44, 0};
    tbl[11] = '{0, 64'h0,  1, 0, 0, 1, 1, 64'h55, 0};

    #1;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].ce);
      model_step(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].ce);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.count", i),     64'(bus.count),     64'(tbl[i].cnt));
      chk($sformatf("vec%0d.empty", i),     64'(bus.empty),     64'(tbl[i].emp));
      chk($sformatf("vec%0d.underflow", i), 64'(bus.underflow), 64'(tbl[i].udf));
`ifndef FIFO_SYNC_FWFT_EN
      chk($sformatf("vec%0d.rd_valid", i),  64'(bus.rd_valid),  64'(tbl[i].rdv));
      chk($sformatf("vec%0d.rd_data", i),   bus.rd_data,        tbl[i].rdd);
`endif
    end

    // Fill to full, then overflow and clear
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 64'(i) + 64'h1000, 1'b0, 1'b0, "fill");
      if (i == AF_LEVEL - 2) chk("fill.af_below", 64'(bus.almost_full), 64'd0);
      if (i == AF_LEVEL - 1) chk("fill.af_at",    64'(bus.almost_full), 64'd1);
    end
    chk("fill.full",  64'(bus.full),  64'd1);
    chk("fill.count", 64'(bus.count), 64'd256);
    cycle(1'b1, 64'hDEAD, 1'b0, 1'b0, "ovf");
    chk("ovf.count",    64'(bus.count),    64'd256);
    chk("ovf.overflow", 64'(bus.overflow), 64'd1);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, "clr");
    chk("clr.overflow", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, "drain");

    // Read on empty straight after reset
    do_reset();
    cycle(1'b0, 64'h0, 1'b1, 1'b0, "udf");
    chk("udf.rd_valid",  64'(bus.rd_valid),  64'd0);
    chk("udf.underflow", 64'(bus.underflow), 64'd1);
    chk("udf.count",     64'(bus.count),     64'd0);
    cycle(1'b1, 64'h5A5A, 1'b0, 1'b0, "udf_wr");
    cycle(1'b0, 64'h0, 1'b1, 1'b0, "udf_rd");

    // Steady occupancy of 100 with simultaneous traffic across several wraps
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, "pre100");
    for (int i = 0; i < 3 * DEPTH; i++) begin
      d = {$urandom, $urandom};
      cycle(1'b1, d, 1'b1, 1'b0, "wrap");
      if (i == 49) chk("wrap.count50", 64'(bus.count), 64'd100);
    end
    chk("wrap.count_end", 64'(bus.count), 64'd100);
    for (int i = 0; i < 100; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, "post100");

    // Asynchronous reset with five words held and a read in flight
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 64'(i) + 64'hA0, 1'b0, 1'b0, "ar_fill");
    cycle(1'b0, 64'h0, 1'b1, 1'b0, "ar_read");
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async.count",    64'(bus.count),    64'd0);
    chk("async.empty",    64'(bus.empty),    64'd1);
    chk("async.full",     64'(bus.full),     64'd0);
    chk("async.rd_valid", 64'(bus.rd_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 64'h77, 1'b0, 1'b0, "ar_new_wr");
    cycle(1'b0, 64'h0, 1'b1, 1'b0, "ar_new_rd");
    chk("async.new_data", bus.rd_data, 64'h77);

`ifdef FIFO_SYNC_FWFT_EN
    do_reset();
    cycle(1'b1, 64'hAB, 1'b0, 1'b0, "fwft_wr");
    chk("fwft.rd_valid", 64'(bus.rd_valid), 64'd1);
    chk("fwft.rd_data",  bus.rd_data,       64'hAB);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, "fwft_pop");
    chk("fwft.pop_valid", 64'(bus.rd_valid), 64'd0);
`endif

    // Random traffic alternating between fill-biased and drain-biased phases
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      p_w = ((i / 300) % 2 == 0) ? 75 : 25;
      cycle($urandom_range(0, 99) < p_w, {$urandom, $urandom},
            $urandom_range(0, 99) < (100 - p_w), $urandom_range(0, 31) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
